// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial addition sequencer that time-shares one external 1-bit full
//   adder. Two WIDTH-bit operands and a carry-in are captured on a start
//   request. They are presented to the adder one bit per clock, LSB first.
//   The ripple carry is held in a register between bits. The WIDTH-bit sum
//   and carry-out are returned together with a one-cycle done strobe.
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous reset, active-low
//   start    operation request, only honoured in IDLE
//   a, b     WIDTH-bit operands, captured when start is accepted
//   cin      initial carry, captured when start is accepted
//   busy     high while bits are being processed (RUN)
//   done     one-cycle strobe, sum/cout valid
//   sum      registered result, held until the next completed operation
//   cout     registered final carry
//   fa_x     to external adder X
//   fa_y     to external adder Y
//   fa_cin   to external adder C_in
//   fa_z     from external adder Z
//   fa_cout  from external adder C_out
module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_cin,
  input  logic             fa_z,
  input  logic             fa_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_sr_q;
  logic [WIDTH-1:0]   b_sr_q;
  logic [WIDTH-1:0]   res_sr_q;
  logic [WIDTH-1:0]   res_sr_d;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               in_run;

  // Result bits arrive LSB first, so each new bit enters at the MSB end.
  // After WIDTH shifts the first bit has reached position 0.
  // With a single bit there is nothing to shift.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_sr_d = fa_z;
    end else begin : g_res_wn
      assign res_sr_d = {fa_z, res_sr_q[WIDTH-1:1]};
    end
  endgenerate

  // The adder is driven only in RUN. It is held at zero otherwise, so the
  // shared cell sees quiet inputs while this block is idle.
  assign in_run = (state_q == RUN);
  assign fa_x   = in_run & a_sr_q[0];
  assign fa_y   = in_run & b_sr_q[0];
  assign fa_cin = in_run & carry_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_sr_q <= res_sr_d;
          carry_q  <= fa_cout;
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          // The adder output for the final bit is still combinational here.
          // The result is therefore taken from res_sr_d, not from res_sr_q.
          if (cnt_q == LAST_CNT) begin
            sum_q   <= res_sr_d;
            cout_q  <= fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl.
// One instance uses WIDTH=8 and a second uses WIDTH=2.
// Each instance has its own full-adder model.
// Expected values come from plain arithmetic (a+b+cin, partial sums for the
// ripple carry). Expected timing comes from the latency rule:
//   busy in k+1..k+W, done in k+W+1, next accept no earlier than k+W+2.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- WIDTH=8 instance ----------------
  logic       rst8_n, start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       fa_x8, fa_y8, fa_cin8, fa_z8, fa_cout8;
  assign {fa_cout8, fa_z8} = 2'(fa_x8) + 2'(fa_y8) + 2'(fa_cin8);

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .fa_x(fa_x8), .fa_y(fa_y8), .fa_cin(fa_cin8), .fa_z(fa_z8), .fa_cout(fa_cout8)
  );

  // ---------------- WIDTH=2 instance ----------------
  logic       rst2_n, start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;
  logic       fa_x2, fa_y2, fa_cin2, fa_z2, fa_cout2;
  assign {fa_cout2, fa_z2} = 2'(fa_x2) + 2'(fa_y2) + 2'(fa_cin2);

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
    .fa_x(fa_x2), .fa_y(fa_y2), .fa_cin(fa_cin2), .fa_z(fa_z2), .fa_cout(fa_cout2)
  );

  // Last completed 8-bit result, which the outputs must keep holding.
  logic [8:0] prev8;

  // Carry into bit i. It equals 1 when the low i bits of a and b, plus cin,
  // overflow i bits.
  function automatic logic carry_into(input logic [7:0] a, input logic [7:0] b,
                                      input logic c, input int i);
    int s;
    s = (int'(a) % (1 << i)) + (int'(b) % (1 << i)) + int'(c);
    return (s >= (1 << i));
  endfunction

  task automatic test_reset();
    rst8_n = 1'b0; rst2_n = 1'b0;
    start8 = 1'b1; start2 = 1'b1;
    a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1;
    a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy8, done8, sum8, cout8, fa_x8, fa_y8, fa_cin8} !== 14'd0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b fa=%b%b%b, required all zero",
               busy8, done8, sum8, cout8, fa_x8, fa_y8, fa_cin8);
    end
    checks++;
    if ({busy2, done2, sum2, cout2, fa_x2, fa_y2, fa_cin2} !== 8'd0) begin
      errors++;
      $display("FAIL reset2: busy=%b done=%b sum=%h cout=%b fa=%b%b%b, required all zero",
               busy2, done2, sum2, cout2, fa_x2, fa_y2, fa_cin2);
    end
    start8 = 1'b0; start2 = 1'b0;
    rst8_n = 1'b1; rst2_n = 1'b1;
    prev8 = 9'd0;
    @(negedge clk);
    $display("reset: both instances checked");
  endtask

  // One full 8-bit operation with cycle-accurate checking.
  // Operand inputs are scrambled after acceptance.
  // start is toggled randomly while the operation is in flight.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input string name);
    logic [8:0] exp_total;
    logic [2:0] exp_fa;
    exp_total = 9'(a) + 9'(b) + 9'(c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);  // accepted at the edge just passed: RUN bit 0
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      start8 = 1'($urandom_range(0, 1));
      exp_fa = {a[i], b[i], carry_into(a, b, c, i)};
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
        errors++;
        $display("FAIL %s run%0d busy/done: got %b/%b required 1/0", name, i, busy8, done8);
      end
      checks++;
      if ({fa_x8, fa_y8, fa_cin8} !== exp_fa) begin
        errors++;
        $display("FAIL %s run%0d fa x/y/cin: got %b%b%b required %b",
                 name, i, fa_x8, fa_y8, fa_cin8, exp_fa);
      end
      if (i == 0) begin
        checks++;
        if ({cout8, sum8} !== prev8) begin
          errors++;
          $display("FAIL %s hold: got %h required %h", name, {cout8, sum8}, prev8);
        end
      end
      @(negedge clk);
    end
    // DONE cycle
    start8 = 1'($urandom_range(0, 1));
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || {fa_x8, fa_y8, fa_cin8} !== 3'b000) begin
      errors++;
      $display("FAIL %s done cycle: done=%b busy=%b fa=%b%b%b required 1/0/000",
               name, done8, busy8, fa_x8, fa_y8, fa_cin8);
    end
    checks++;
    if ({cout8, sum8} !== exp_total) begin
      errors++;
      $display("FAIL %s result: cout/sum=%b/%h required %b/%h",
               name, cout8, sum8, exp_total[8], exp_total[7:0]);
    end
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || {fa_x8, fa_y8, fa_cin8} !== 3'b000) begin
      errors++;
      $display("FAIL %s idle after done: done=%b busy=%b fa=%b%b%b required 0/0/000",
               name, done8, busy8, fa_x8, fa_y8, fa_cin8);
    end
    prev8 = exp_total;
    $display("%s: a=%h b=%h cin=%b -> cout=%b sum=%h", name, a, b, c, cout8, sum8);
  endtask

  task automatic test_directed();
    run_op8(8'h5A, 8'h33, 1'b0, "add_5a_33");
    checks++;
    if (sum8 !== 8'h8D || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL add_5a_33 const: got %b/%h required 0/8d", cout8, sum8);
    end
    run_op8(8'hFF, 8'h01, 1'b0, "add_ff_01");
    run_op8(8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");
    checks++;
    if (sum8 !== 8'hFF || cout8 !== 1'b1) begin
      errors++;
      $display("FAIL add_ff_ff_c const: got %b/%h required 1/ff", cout8, sum8);
    end
  endtask

  task automatic test_fa_drive();
    // Expected carry-in sequence for this case is 0,1,1,1,1,0,0,0.
    run_op8(8'h0F, 8'h01, 1'b0, "fa_drive_0f_01");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_back_to_back();
    int last_acc;
    int dones;
    logic exp_busy, exp_done;
    last_acc = -100;
    dones = 0;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      start8 = (c < 20);
      // Acceptance rule: start is high and the previous op has fully retired.
      if (c < 20 && c >= last_acc + 10) last_acc = c;
      exp_busy = (c >= last_acc) && (c <= last_acc + 7);
      exp_done = (c == last_acc + 8);
      @(negedge clk);
      checks++;
      if (busy8 !== exp_busy || done8 !== exp_done) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: busy/done=%b/%b required %b/%b",
                 c, busy8, done8, exp_busy, exp_done);
      end
      if (done8 === 1'b1) begin
        dones++;
        checks++;
        if (sum8 !== 8'h30 || cout8 !== 1'b0) begin
          errors++;
          $display("FAIL back_to_back result: got %b/%h required 0/30", cout8, sum8);
        end
      end
    end
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL back_to_back done count: got %0d required 2", dones);
    end
    prev8 = 9'h030;
    $display("back_to_back: %0d done pulses", dones);
  endtask

  task automatic test_reset_mid_run();
    int stray;
    stray = 0;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);  // RUN cycle 1
    start8 = 1'b0;
    repeat (3) @(negedge clk);  // now in RUN cycle 4
    rst8_n = 1'b0;
    @(negedge clk);
    rst8_n = 1'b1;
    checks++;
    if ({busy8, done8, sum8, cout8, fa_x8, fa_y8, fa_cin8} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b fa=%b%b%b required all zero",
               busy8, done8, sum8, cout8, fa_x8, fa_y8, fa_cin8);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_mid_run stray activity: got %0d cycles required 0", stray);
    end
    prev8 = 9'd0;
    $display("reset_mid_run: aborted, stray cycles=%0d", stray);
    run_op8(8'h01, 8'h01, 1'b0, "after_reset_01_01");
  endtask

  task automatic test_exhaustive_w2();
    logic [4:0] v;
    logic [2:0] exp_total;
    int dones;
    @(negedge clk);
    for (int n = 0; n < 32; n++) begin
      v = 5'(n);
      exp_total = 3'(v[1:0]) + 3'(v[3:2]) + 3'(v[4]);
      a2 = v[1:0]; b2 = v[3:2]; cin2 = v[4]; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      a2 = 2'($urandom); b2 = 2'($urandom);
      dones = 0;
      for (int j = 0; j < 4; j++) begin
        if (done2 === 1'b1) dones++;
        if (j == 2) begin
          checks++;
          if (done2 !== 1'b1 || {cout2, sum2} !== exp_total) begin
            errors++;
            $display("FAIL w2 a=%0d b=%0d cin=%0d: done=%b cout/sum=%b/%0d required 1/%b/%0d",
                     v[1:0], v[3:2], v[4], done2, cout2, sum2, exp_total[2], exp_total[1:0]);
          end
        end
        if (j < 3) @(negedge clk);
      end
      checks++;
      if (dones != 1) begin
        errors++;
        $display("FAIL w2 done count case %0d: got %0d required 1", n, dones);
      end
      $display("w2: a=%0d b=%0d cin=%0d -> cout=%b sum=%0d", v[1:0], v[3:2], v[4], cout2, sum2);
    end
  endtask

  initial begin
    rst8_n = 1'b0; rst2_n = 1'b0;
    start8 = 1'b0; start2 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    a2 = '0; b2 = '0; cin2 = 1'b0;
    prev8 = 9'd0;
    test_reset();
    test_directed();
    test_fa_drive();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive_w2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
